reg_scoreboard: RTL and testbench



---
 rtl/global_pkg.sv | 11 +
 rtl/reg_scoreboard_if.sv | 31 +++
 rtl/reg_scoreboard_fifo.sv | 52 +++++
 rtl/reg_scoreboard.sv | 91 +++++++++
 tb/tb_reg_scoreboard.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/global_pkg.sv
// Shared core-wide constants and the register-address type used by the scoreboard slice.
package global_pkg;

    localparam int BIT_DEPTH      = 32;
    localparam int LOG_PORT_DEPTH = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef logic [LOG_PORT_DEPTH-1:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard_if.sv
// Decode-issue / writeback-retire bundle between the pipeline (master) and the scoreboard (slave).
interface reg_scoreboard_if #(
    parameter int LOG_PORT_DEPTH = global_pkg::LOG_PORT_DEPTH,
    parameter int INFLIGHT_DEPTH = 4
);

    logic                              IssueValid;
    logic [LOG_PORT_DEPTH-1:0]         IssueRs;
    logic [LOG_PORT_DEPTH-1:0]         IssueRt;
    logic                              IssueUseRt;
    logic                              IssueRegWrite;
    logic [LOG_PORT_DEPTH-1:0]         IssueDest;
    logic                              Stall;
    logic                              RetireValid;
    logic [LOG_PORT_DEPTH-1:0]         RetireAddr;
    logic [$clog2(INFLIGHT_DEPTH):0]   InFlight;
    logic                              OrderErr;

    modport master (
        output IssueValid, IssueRs, IssueRt, IssueUseRt, IssueRegWrite, IssueDest,
        output RetireValid, RetireAddr,
        input  Stall, InFlight, OrderErr
    );

    modport slave (
        input  IssueValid, IssueRs, IssueRt, IssueUseRt, IssueRegWrite, IssueDest,
        input  RetireValid, RetireAddr,
        output Stall, InFlight, OrderErr
    );

endinterface

// File: rtl/reg_scoreboard_fifo.sv
// inflight_fifo: in-order queue of outstanding destinations; pointers carry an extra wrap bit.
module inflight_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W:0]   wr_q, wr_d;
    logic [PTR_W:0]   rd_q, rd_d;

    // The owner never pushes when full nor pops when empty, so no guards here.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        if (push) begin
            mem_d[wr_q[PTR_W-1:0]] = push_data;
            wr_d                   = wr_q + 1'b1;
        end
        if (pop) begin
            rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_q[PTR_W-1:0]];
    assign count = wr_q - rd_q;

endmodule

// File: rtl/reg_scoreboard.sv
// RAW/WAW decode-stall scoreboard with an in-order retire check.
// Define REG_SCOREBOARD_BYPASS_EN to let an in-order retire unblock its dependants in the same cycle.
module reg_scoreboard
    import global_pkg::*;
#(
    parameter int BIT_DEPTH      = global_pkg::BIT_DEPTH,
    parameter int LOG_PORT_DEPTH = global_pkg::LOG_PORT_DEPTH,
    parameter int INFLIGHT_DEPTH = 4
) (
    input logic            clk,
    input logic            rst,
    reg_scoreboard_if.slave sb
);

    localparam int NUM_REGS = 2 ** LOG_PORT_DEPTH;
    localparam int CNT_W    = $clog2(INFLIGHT_DEPTH) + 1;
    localparam logic [LOG_PORT_DEPTH-1:0] ZERO = LOG_PORT_DEPTH'(REG_ZERO);

    if (BIT_DEPTH < 1 || INFLIGHT_DEPTH < 2 || (INFLIGHT_DEPTH & (INFLIGHT_DEPTH - 1)) != 0) begin : g_bad_param
        $error("reg_scoreboard: INFLIGHT_DEPTH must be a power of two >= 2");
    end

    logic [NUM_REGS-1:0]       pend_q, pend_d, pend_view;
    logic [LOG_PORT_DEPTH-1:0] fifo_head;
    logic [CNT_W-1:0]          fifo_count;
    logic                      order_err_q, order_err_d;
    logic                      retire_nz, retire_hit;
    logic                      hazard, full, stall, accept;

    // pend_view is what the hazard check sees; only bypass builds hide a retiring register.
    always_comb begin
        retire_nz  = sb.RetireValid && (sb.RetireAddr != ZERO);
        retire_hit = retire_nz && (fifo_count != '0) && (fifo_head == sb.RetireAddr);

        pend_view = pend_q;
`ifdef REG_SCOREBOARD_BYPASS_EN
        if (retire_hit) begin
            pend_view[sb.RetireAddr] = 1'b0;
        end
`endif
        pend_view[0] = 1'b0;

        hazard = sb.IssueValid &&
                 (pend_view[sb.IssueRs] ||
                  (sb.IssueUseRt    && pend_view[sb.IssueRt]) ||
                  (sb.IssueRegWrite && pend_view[sb.IssueDest]));
        full   = sb.IssueValid && sb.IssueRegWrite && (sb.IssueDest != ZERO) &&
                 (fifo_count == CNT_W'(INFLIGHT_DEPTH));
        stall  = hazard || full;
        accept = sb.IssueValid && !stall && sb.IssueRegWrite && (sb.IssueDest != ZERO);

        pend_d = pend_q;
        if (retire_hit) begin
            pend_d[sb.RetireAddr] = 1'b0;
        end
        if (accept) begin
            pend_d[sb.IssueDest] = 1'b1;
        end
        pend_d[0] = 1'b0;

        order_err_d = order_err_q || (retire_nz && !retire_hit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q      <= '0;
            order_err_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            order_err_q <= order_err_d;
        end
    end

    inflight_fifo #(
        .WIDTH (LOG_PORT_DEPTH),
        .DEPTH (INFLIGHT_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept),
        .push_data (sb.IssueDest),
        .pop       (retire_hit),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign sb.Stall    = stall;
    assign sb.InFlight = fifo_count;
    assign sb.OrderErr = order_err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized plus directed bench for reg_scoreboard; the reference keeps outstanding writes as a queue.
// Compile with +define+REG_SCOREBOARD_BYPASS_EN to exercise the bypass build.
module tb_reg_scoreboard;

    localparam int LPD   = 5;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reg_scoreboard_if #(.LOG_PORT_DEPTH(LPD), .INFLIGHT_DEPTH(DEPTH)) sbIf ();

    reg_scoreboard #(
        .BIT_DEPTH      (32),
        .LOG_PORT_DEPTH (LPD),
        .INFLIGHT_DEPTH (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sb  (sbIf.slave)
    );

    int compareCount = 0;
    int failCount    = 0;

    logic [LPD-1:0] modelQ[$];
    bit             modelErr = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // A register is busy while some outstanding write to it sits in the queue.
    function automatic bit modelBusy(input logic [LPD-1:0] r, input bit skipHead);
        if (r == 0) return 1'b0;
        foreach (modelQ[i]) begin
            if (modelQ[i] == r && !(skipHead && i == 0)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Drives one cycle from the negedge, checks outputs, then advances the model at the posedge.
    task automatic applyStimulus(input bit doRst, input bit v, input logic [LPD-1:0] rs,
                                 input logic [LPD-1:0] rt, input bit useRt, input bit rw,
                                 input logic [LPD-1:0] dest, input bit rv,
                                 input logic [LPD-1:0] raddr, output bit dutIssued);
        bit retireHit, skipHead, hazard, full, expStall, modelAccept;
        rst                = doRst;
        sbIf.IssueValid    = v;
        sbIf.IssueRs       = rs;
        sbIf.IssueRt       = rt;
        sbIf.IssueUseRt    = useRt;
        sbIf.IssueRegWrite = rw;
        sbIf.IssueDest     = dest;
        sbIf.RetireValid   = rv;
        sbIf.RetireAddr    = raddr;
        #1;
        retireHit = rv && raddr != 0 && modelQ.size() > 0 && modelQ[0] == raddr;
        skipHead  = 1'b0;
`ifdef REG_SCOREBOARD_BYPASS_EN
        skipHead  = retireHit;
`endif
        hazard   = modelBusy(rs, skipHead) || (useRt && modelBusy(rt, skipHead)) ||
                   (rw && modelBusy(dest, skipHead));
        full     = rw && dest != 0 && modelQ.size() == DEPTH;
        expStall = v && (hazard || full);
        checkOutput("stall", {31'd0, sbIf.Stall}, {31'd0, expStall});
        checkOutput("inflight", 32'(sbIf.InFlight), 32'(modelQ.size()));
        checkOutput("ordererr", {31'd0, sbIf.OrderErr}, {31'd0, modelErr});
        dutIssued   = v && !sbIf.Stall;
        modelAccept = v && !expStall && rw && dest != 0;
        @(posedge clk);
        if (doRst) begin
            modelQ.delete();
            modelErr = 1'b0;
        end else begin
            if (rv && raddr != 0) begin
                if (retireHit) void'(modelQ.pop_front());
                else modelErr = 1'b1;
            end
            if (modelAccept) modelQ.push_back(dest);
        end
        @(negedge clk);
    endtask

    task automatic idleCycle(input bit doRst);
        bit unusedIssued;
        applyStimulus(doRst, 0, 0, 0, 0, 0, 0, 0, 0, unusedIssued);
    endtask

    initial begin
        bit issued;
        int acceptCycle;
        int expCycle;
        logic [LPD-1:0] nextDest;

        rst = 1'b1;
        sbIf.IssueValid = 0; sbIf.IssueRs = 0; sbIf.IssueRt = 0; sbIf.IssueUseRt = 0;
        sbIf.IssueRegWrite = 0; sbIf.IssueDest = 0; sbIf.RetireValid = 0; sbIf.RetireAddr = 0;
        @(negedge clk);
        idleCycle(1);

        // Reset while an accept of dest 8 is in progress, then a stray retire of 8.
        applyStimulus(1, 1, 0, 0, 0, 1, 8, 0, 0, issued);
        applyStimulus(0, 1, 8, 0, 0, 0, 0, 1, 8, issued);
        checkOutput("rst_no_stall", {31'd0, issued}, 32'd1);
        idleCycle(0);
        checkOutput("rst_ordererr", {31'd0, sbIf.OrderErr}, 32'd1);
        idleCycle(1);

        // RAW: dest 8, then rs=8 held until it issues; retire 8 two cycles later.
        applyStimulus(0, 1, 0, 0, 0, 1, 8, 0, 0, issued);
        acceptCycle = -1;
        for (int cyc = 1; cyc <= 6 && acceptCycle < 0; cyc++) begin
            applyStimulus(0, 1, 8, 0, 0, 0, 0, cyc == 3, 8, issued);
            if (issued) acceptCycle = cyc;
        end
`ifdef REG_SCOREBOARD_BYPASS_EN
        expCycle = 3;
`else
        expCycle = 4;
`endif
        checkOutput("raw_issue_cycle", 32'(acceptCycle), 32'(expCycle));
        idleCycle(1);

        // Register zero is never tracked.
        for (int k = 0; k < 6; k++) begin
            applyStimulus(0, 1, 0, 0, 1, 1, 0, 0, 0, issued);
            checkOutput("zero_issue", {31'd0, issued}, 32'd1);
        end
        idleCycle(0);
        idleCycle(1);

        // Fill to depth, hold dest 5 on Full, then wrap through 12 issue/retire pairs.
        for (int d = 1; d <= 4; d++) applyStimulus(0, 1, 0, 0, 0, 1, 5'(d), 0, 0, issued);
        applyStimulus(0, 1, 0, 0, 0, 1, 5, 0, 0, issued);
        checkOutput("full_stall", {31'd0, issued}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 1, 5, 1, 1, issued);
        checkOutput("full_pop_no_release", {31'd0, issued}, 32'd0);
        applyStimulus(0, 1, 0, 0, 0, 1, 5, 0, 0, issued);
        checkOutput("full_release", {31'd0, issued}, 32'd1);
        nextDest = 6;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, modelQ[0], issued);
            applyStimulus(0, 1, 0, 0, 0, 1, nextDest, 0, 0, issued);
            nextDest = nextDest + 1;
        end
        idleCycle(0);
        checkOutput("wrap_inflight", 32'(sbIf.InFlight), 32'd4);
        checkOutput("wrap_ordererr", {31'd0, sbIf.OrderErr}, 32'd0);
        while (modelQ.size() > 0) applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, modelQ[0], issued);
        idleCycle(1);

        // Out-of-order retire of 4 ahead of 3.
        applyStimulus(0, 1, 0, 0, 0, 1, 3, 0, 0, issued);
        applyStimulus(0, 1, 0, 0, 0, 1, 4, 0, 0, issued);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 4, issued);
        checkOutput("ooo_ordererr", {31'd0, sbIf.OrderErr}, 32'd1);
        checkOutput("ooo_inflight", 32'(sbIf.InFlight), 32'd2);
        applyStimulus(0, 1, 3, 0, 0, 0, 0, 0, 0, issued);
        checkOutput("ooo_p3_held", {31'd0, issued}, 32'd0);
        applyStimulus(0, 1, 0, 4, 1, 0, 0, 0, 0, issued);
        checkOutput("ooo_p4_held", {31'd0, issued}, 32'd0);
        idleCycle(1);

        // Retire the head and accept a new dest in the same cycle.
        applyStimulus(0, 1, 0, 0, 0, 1, 10, 0, 0, issued);
        applyStimulus(0, 1, 0, 0, 0, 1, 11, 0, 0, issued);
        applyStimulus(0, 1, 0, 0, 0, 1, 12, 1, 10, issued);
        checkOutput("simul_inflight", 32'(sbIf.InFlight), 32'd2);
        applyStimulus(0, 1, 10, 0, 0, 0, 0, 0, 0, issued);
        checkOutput("simul_p10_clear", {31'd0, issued}, 32'd1);
        applyStimulus(0, 1, 12, 0, 0, 0, 0, 0, 0, issued);
        checkOutput("simul_p12_set", {31'd0, issued}, 32'd0);
        idleCycle(1);

        // Random traffic over a small register window so hazards are frequent.
        for (int k = 0; k < 400; k++) begin
            bit rv;
            logic [LPD-1:0] raddr;
            if ($urandom_range(0, 9) < 6 && modelQ.size() > 0) begin
                rv    = 1'b1;
                raddr = modelQ[0];
            end else begin
                rv    = ($urandom_range(0, 4) == 0);
                raddr = 5'($urandom_range(0, 7));
            end
            applyStimulus($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                          5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 7)), rv, raddr, issued);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
